// File: rtl/rgb_to_yuv_encoder.sv
// RGB-to-YUV frame encoder.
// Reads a packed RGB frame from the shared SRAM, four pixels (six words) at a time.
// Converts each pixel to Y/U/V with Q16 fixed-point arithmetic.
// Writes one Y plane and 2:1 horizontally decimated U and V planes back to SRAM.
module rgb_to_yuv_encoder #(
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter int          NUM_GROUPS = 19200
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  localparam int DATA_W = 8;
  localparam int COEF_W = 32;
  localparam int GRP_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GRP_W-1:0] LAST_G = GRP_W'(NUM_GROUPS - 1);

  typedef enum logic [4:0] {
    S_IDLE,
    S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5,
    S_CAP4, S_CAP5,
    S_CONV0, S_CONV1, S_CONV2, S_CONV3,
    S_WY0, S_WY1, S_WU, S_WV,
    S_DONE
  } state_t;

  state_t            state;
  logic [GRP_W-1:0]  grp;
  logic [17:0]       rgb_ptr;
  logic [17:0]       y_ptr;
  logic [17:0]       uv_off;

  // Six captured RGB words of the current group, then per-pixel Y/U/V results
  logic [15:0]       word_p0 [6];
  logic [DATA_W-1:0] y_p1 [4];
  logic [DATA_W-1:0] u_p1 [4];
  logic [DATA_W-1:0] v_p1 [4];

  logic [DATA_W-1:0] cur_r, cur_g, cur_b;
  logic [DATA_W-1:0] y_c, u_c, v_c;

  // Weighted sum with rounding bias, then arithmetic shift (floor) back to integer
  function automatic logic signed [COEF_W-1:0] dot_q16(
    input logic signed [COEF_W-1:0] c_r,
    input logic signed [COEF_W-1:0] c_g,
    input logic signed [COEF_W-1:0] c_b,
    input logic [DATA_W-1:0]        r,
    input logic [DATA_W-1:0]        g,
    input logic [DATA_W-1:0]        b
  );
    logic signed [COEF_W-1:0] rs, gs, bs, acc;
    rs  = $signed({{(COEF_W-DATA_W){1'b0}}, r});
    gs  = $signed({{(COEF_W-DATA_W){1'b0}}, g});
    bs  = $signed({{(COEF_W-DATA_W){1'b0}}, b});
    acc = c_r * rs + c_g * gs + c_b * bs + 32'sd32768;
    return acc >>> 16;
  endfunction

  // Saturate a signed value into an unsigned 8-bit sample
  function automatic logic [DATA_W-1:0] clip_u8(input logic signed [COEF_W-1:0] x);
    if (x < 0)
      return '0;
    else if (x > 32'sd255)
      return 8'hFF;
    else
      return x[DATA_W-1:0];
  endfunction

  // Rounded pair average, carried in 9 bits and truncated back to 8
  function automatic logic [DATA_W-1:0] avg8(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[DATA_W:1];
  endfunction

  // Select the pixel being converted this cycle from the captured words
  always_comb begin
    cur_r = '0;
    cur_g = '0;
    cur_b = '0;
    case (state)
      S_CONV0: begin cur_r = word_p0[0][15:8]; cur_g = word_p0[0][7:0];  cur_b = word_p0[1][15:8]; end
      S_CONV1: begin cur_r = word_p0[1][7:0];  cur_g = word_p0[2][15:8]; cur_b = word_p0[2][7:0];  end
      S_CONV2: begin cur_r = word_p0[3][15:8]; cur_g = word_p0[3][7:0];  cur_b = word_p0[4][15:8]; end
      S_CONV3: begin cur_r = word_p0[4][7:0];  cur_g = word_p0[5][15:8]; cur_b = word_p0[5][7:0];  end
      default: ;
    endcase
  end

  // Colour-space conversion of the selected pixel
  always_comb begin
    y_c = clip_u8(dot_q16( 32'sd16843,  32'sd33030,  32'sd6423,  cur_r, cur_g, cur_b) + 32'sd16);
    u_c = clip_u8(dot_q16(-32'sd9699,  -32'sd19071,  32'sd28770, cur_r, cur_g, cur_b) + 32'sd128);
    v_c = clip_u8(dot_q16( 32'sd28770, -32'sd24117, -32'sd4653,  cur_r, cur_g, cur_b) + 32'sd128);
  end

  // Group sequencer: read six words, convert four pixels, write four words
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state           <= S_IDLE;
      grp             <= '0;
      rgb_ptr         <= '0;
      y_ptr           <= '0;
      uv_off          <= '0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Done            <= 1'b0;
      for (int i = 0; i < 6; i++) word_p0[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        y_p1[i] <= '0;
        u_p1[i] <= '0;
        v_p1[i] <= '0;
      end
    end else begin
      SRAM_we_n <= 1'b1;
      Done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Enable) begin
            grp     <= '0;
            rgb_ptr <= RGB_BASE;
            y_ptr   <= Y_BASE;
            uv_off  <= '0;
            state   <= S_RD0;
          end
        end
        // Read issue; data of each address returns two edges later
        S_RD0: begin
          SRAM_address <= rgb_ptr;
          rgb_ptr      <= rgb_ptr + 18'd1;
          state        <= S_RD1;
        end
        S_RD1: begin
          SRAM_address <= rgb_ptr;
          rgb_ptr      <= rgb_ptr + 18'd1;
          state        <= S_RD2;
        end
        S_RD2: begin
          SRAM_address <= rgb_ptr;
          rgb_ptr      <= rgb_ptr + 18'd1;
          word_p0[0]   <= SRAM_read_data;
          state        <= S_RD3;
        end
        S_RD3: begin
          SRAM_address <= rgb_ptr;
          rgb_ptr      <= rgb_ptr + 18'd1;
          word_p0[1]   <= SRAM_read_data;
          state        <= S_RD4;
        end
        S_RD4: begin
          SRAM_address <= rgb_ptr;
          rgb_ptr      <= rgb_ptr + 18'd1;
          word_p0[2]   <= SRAM_read_data;
          state        <= S_RD5;
        end
        S_RD5: begin
          SRAM_address <= rgb_ptr;
          rgb_ptr      <= rgb_ptr + 18'd1;
          word_p0[3]   <= SRAM_read_data;
          state        <= S_CAP4;
        end
        S_CAP4: begin
          word_p0[4] <= SRAM_read_data;
          state      <= S_CAP5;
        end
        S_CAP5: begin
          word_p0[5] <= SRAM_read_data;
          state      <= S_CONV0;
        end
        // Conversion: one pixel per cycle into the result registers
        S_CONV0: begin
          y_p1[0] <= y_c; u_p1[0] <= u_c; v_p1[0] <= v_c;
          state   <= S_CONV1;
        end
        S_CONV1: begin
          y_p1[1] <= y_c; u_p1[1] <= u_c; v_p1[1] <= v_c;
          state   <= S_CONV2;
        end
        S_CONV2: begin
          y_p1[2] <= y_c; u_p1[2] <= u_c; v_p1[2] <= v_c;
          state   <= S_CONV3;
        end
        S_CONV3: begin
          y_p1[3] <= y_c; u_p1[3] <= u_c; v_p1[3] <= v_c;
          state   <= S_WY0;
        end
        // Write-back: two Y words, one decimated U word, one decimated V word
        S_WY0: begin
          SRAM_address    <= y_ptr;
          SRAM_write_data <= {y_p1[0], y_p1[1]};
          SRAM_we_n       <= 1'b0;
          y_ptr           <= y_ptr + 18'd1;
          state           <= S_WY1;
        end
        S_WY1: begin
          SRAM_address    <= y_ptr;
          SRAM_write_data <= {y_p1[2], y_p1[3]};
          SRAM_we_n       <= 1'b0;
          y_ptr           <= y_ptr + 18'd1;
          state           <= S_WU;
        end
        S_WU: begin
          SRAM_address    <= U_BASE + uv_off;
          SRAM_write_data <= {avg8(u_p1[0], u_p1[1]), avg8(u_p1[2], u_p1[3])};
          SRAM_we_n       <= 1'b0;
          state           <= S_WV;
        end
        S_WV: begin
          SRAM_address    <= V_BASE + uv_off;
          SRAM_write_data <= {avg8(v_p1[0], v_p1[1]), avg8(v_p1[2], v_p1[3])};
          SRAM_we_n       <= 1'b0;
          uv_off          <= uv_off + 18'd1;
          if (grp == LAST_G) begin
            state <= S_DONE;
          end else begin
            grp   <= grp + 1'b1;
            state <= S_RD0;
          end
        end
        S_DONE: begin
          Done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Testbench for rgb_to_yuv_encoder on a reduced frame, with an SRAM model
// and a plain-arithmetic reference of the colour conversion and plane layout.
module tb_rgb_to_yuv_encoder;

  localparam int          N  = 8;
  localparam logic [17:0] YB = 18'd0;
  localparam logic [17:0] UB = 18'd38400;
  localparam logic [17:0] VB = 18'd57600;
  localparam logic [17:0] RB = 18'd146944;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Enable = 1'b0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Done;

  logic [15:0] mem [0:262143];
  logic [15:0] rd_q = 16'h0;
  logic        poke_en = 1'b0;
  logic [17:0] poke_addr = '0;
  logic [15:0] poke_data = '0;
  int          wr_cnt = 0;
  int          bad_wr = 0;

  int n_tests = 0;
  int n_fail  = 0;

  int pr [4*N];
  int pg [4*N];
  int pb [4*N];

  always #5 Clock = ~Clock;

  rgb_to_yuv_encoder #(
    .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .RGB_BASE(RB), .NUM_GROUPS(N)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Enable(Enable),
    .SRAM_address(SRAM_address),
    .SRAM_read_data(SRAM_read_data),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n),
    .Done(Done)
  );

  assign SRAM_read_data = rd_q;

  // SRAM: registered read (two-edge latency seen from the address register), synchronous write
  always @(posedge Clock) begin
    rd_q <= mem[SRAM_address];
    if (poke_en)
      mem[poke_addr] <= poke_data;
    else if (!SRAM_we_n) begin
      mem[SRAM_address] <= SRAM_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Any write outside the three planes is recorded
  always @(posedge Clock) begin
    if (!SRAM_we_n &&
        !((int'(SRAM_address) >= int'(YB) && int'(SRAM_address) < int'(YB) + 2*N) ||
          (int'(SRAM_address) >= int'(UB) && int'(SRAM_address) < int'(UB) + N) ||
          (int'(SRAM_address) >= int'(VB) && int'(SRAM_address) < int'(VB) + N)))
      bad_wr <= bad_wr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [15:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en   = 1'b0;
  endtask

  // Reference model: floor division by 2^16, clipping, conversion, rounding average
  function automatic int floor_q16(input int v);
    if (v >= 0) return v / 65536;
    return -((-v + 65535) / 65536);
  endfunction

  function automatic int clip(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int ref_y(input int r, input int g, input int b);
    return clip(floor_q16(16843*r + 33030*g + 6423*b + 32768) + 16);
  endfunction

  function automatic int ref_u(input int r, input int g, input int b);
    return clip(floor_q16(-9699*r - 19071*g + 28770*b + 32768) + 128);
  endfunction

  function automatic int ref_v(input int r, input int g, input int b);
    return clip(floor_q16(28770*r - 24117*g - 4653*b + 32768) + 128);
  endfunction

  function automatic int avg(input int a, input int b);
    return (a + b + 1) / 2;
  endfunction

  task automatic set_px(input int i, input int r, input int g, input int b);
    pr[i] = r; pg[i] = g; pb[i] = b;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4*N; i++)
      set_px(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 4*N; i++) set_px(i, v, v, v);
  endtask

  // Pack pixel pairs as {R0,G0},{B0,R1},{G1,B1}
  task automatic load_frame();
    for (int p = 0; p < 2*N; p++) begin
      poke(RB + 18'(3*p),     16'((pr[2*p] << 8) | pg[2*p]));
      poke(RB + 18'(3*p + 1), 16'((pb[2*p] << 8) | pr[2*p+1]));
      poke(RB + 18'(3*p + 2), 16'((pg[2*p+1] << 8) | pb[2*p+1]));
    end
  endtask

  task automatic clear_planes(input logic [15:0] s);
    for (int i = 0; i < 2*N; i++) poke(YB + 18'(i), s);
    for (int i = 0; i < N; i++) begin
      poke(UB + 18'(i), s);
      poke(VB + 18'(i), s);
    end
  endtask

  function automatic logic [15:0] exp_y(input int w);
    return 16'((ref_y(pr[2*w], pg[2*w], pb[2*w]) << 8) | ref_y(pr[2*w+1], pg[2*w+1], pb[2*w+1]));
  endfunction

  task automatic check_planes(input string tag);
    int u0, u1, u2, u3, v0, v1, v2, v3;
    for (int g = 0; g < N; g++) begin
      u0 = ref_u(pr[4*g],   pg[4*g],   pb[4*g]);
      u1 = ref_u(pr[4*g+1], pg[4*g+1], pb[4*g+1]);
      u2 = ref_u(pr[4*g+2], pg[4*g+2], pb[4*g+2]);
      u3 = ref_u(pr[4*g+3], pg[4*g+3], pb[4*g+3]);
      v0 = ref_v(pr[4*g],   pg[4*g],   pb[4*g]);
      v1 = ref_v(pr[4*g+1], pg[4*g+1], pb[4*g+1]);
      v2 = ref_v(pr[4*g+2], pg[4*g+2], pb[4*g+2]);
      v3 = ref_v(pr[4*g+3], pg[4*g+3], pb[4*g+3]);
      check($sformatf("%s_y%0d", tag, 2*g),   32'(mem[YB + 18'(2*g)]),   32'(exp_y(2*g)));
      check($sformatf("%s_y%0d", tag, 2*g+1), 32'(mem[YB + 18'(2*g+1)]), 32'(exp_y(2*g+1)));
      check($sformatf("%s_u%0d", tag, g), 32'(mem[UB + 18'(g)]), 32'((avg(u0, u1) << 8) | avg(u2, u3)));
      check($sformatf("%s_v%0d", tag, g), 32'(mem[VB + 18'(g)]), 32'((avg(v0, v1) << 8) | avg(v2, v3)));
    end
    check({tag, "_range"}, 32'(bad_wr), 32'd0);
  endtask

  // Tick until Done is seen; cnt = edges since the Enable-accepting edge
  task automatic wait_done(input int start, input bit pulse, output int cnt);
    cnt = start;
    while (cnt < 16*N + 40) begin
      tick();
      cnt++;
      if (pulse) Enable = (cnt == 40);
      if (Done) break;
    end
  endtask

  task automatic run_frame(input string tag, input bit pulse);
    int cnt;
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
    wait_done(0, pulse, cnt);
    Enable = 1'b0;
    // Done is consumed at the edge after it rises: 1 + 16*N + 1 cycles
    check({tag, "_latency"}, 32'(cnt + 1), 32'(16*N + 2));
  endtask

  initial begin
    int cnt;
    int w0;

    // Reset state
    Resetn = 1'b0;
    tick(); tick();
    check("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check("rst_addr", 32'(SRAM_address), 32'd0);
    check("rst_wdata", 32'(SRAM_write_data), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Resetn = 1'b1;
    tick();

    // All-white frame
    fill_const(255); load_frame(); clear_planes(16'hDEAD);
    run_frame("white", 1'b0);
    check_planes("white");
    check("white_y_const", 32'(mem[YB]), 32'h0000EBEB);
    check("white_u_const", 32'(mem[UB]), 32'h00008080);

    // All-black frame
    fill_const(0); load_frame(); clear_planes(16'hDEAD);
    run_frame("black", 1'b0);
    check_planes("black");
    check("black_y_const", 32'(mem[YB + 18'(2*N - 1)]), 32'h00001010);
    check("black_v_const", 32'(mem[VB + 18'(N - 1)]), 32'h00008080);

    // Group 0 = red, red, blue, blue
    fill_random();
    set_px(0, 255, 0, 0); set_px(1, 255, 0, 0); set_px(2, 0, 0, 255); set_px(3, 0, 0, 255);
    load_frame(); clear_planes(16'hDEAD);
    run_frame("rrbb", 1'b0);
    check_planes("rrbb");
    check("rrbb_y0", 32'(mem[YB]), 32'h00005252);
    check("rrbb_y1", 32'(mem[YB + 18'd1]), 32'h00002929);
    check("rrbb_u0", 32'(mem[UB]), 32'h00005AF0);
    check("rrbb_v0", 32'(mem[VB]), 32'h0000F06E);

    // Group 0 = red, blue, red, blue: rounding of the pair average
    fill_random();
    set_px(0, 255, 0, 0); set_px(1, 0, 0, 255); set_px(2, 255, 0, 0); set_px(3, 0, 0, 255);
    load_frame(); clear_planes(16'hDEAD);
    run_frame("rbrb", 1'b0);
    check_planes("rbrb");
    check("rbrb_u0", 32'(mem[UB]), 32'h0000A5A5);
    check("rbrb_v0", 32'(mem[VB]), 32'h0000AFAF);

    // Random frame with Enable pulsed mid-frame
    fill_random(); load_frame(); clear_planes(16'hDEAD);
    run_frame("pulse", 1'b1);
    check_planes("pulse");

    // Reset asserted for the one edge that processes S_WU of group 5
    fill_random(); load_frame(); clear_planes(16'hDEAD);
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
    repeat (16*5 + 14) tick();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    check("midrst_we_n", 32'(SRAM_we_n), 32'd1);
    check("midrst_addr", 32'(SRAM_address), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    w0 = wr_cnt;
    repeat (20) tick();
    check("midrst_no_writes", 32'(wr_cnt), 32'(w0));
    check("midrst_done_idle", 32'(Done), 32'd0);
    check("midrst_y11", 32'(mem[YB + 18'd11]), 32'(exp_y(11)));
    check("midrst_y12", 32'(mem[YB + 18'd12]), 32'h0000DEAD);
    check("midrst_u5", 32'(mem[UB + 18'd5]), 32'h0000DEAD);
    check("midrst_v5", 32'(mem[VB + 18'd5]), 32'h0000DEAD);
    // Restart reads from the first RGB word
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
    tick();
    check("restart_addr", 32'(SRAM_address), 32'(RB));
    wait_done(1, 1'b0, cnt);
    check("restart_latency", 32'(cnt + 1), 32'(16*N + 2));
    check_planes("restart");

    // Enable held high: next frame accepted the edge after Done is seen
    fill_random(); load_frame(); clear_planes(16'hDEAD);
    Enable = 1'b1;
    tick();
    wait_done(0, 1'b0, cnt);
    check("hold_latency", 32'(cnt + 1), 32'(16*N + 2));
    check("hold_done_seen", 32'(Done), 32'd1);
    tick();
    check("hold_done_pulse", 32'(Done), 32'd0);
    tick();
    check("hold_second_addr", 32'(SRAM_address), 32'(RB));
    Enable = 1'b0;
    wait_done(1, 1'b0, cnt);
    check("hold_second_latency", 32'(cnt + 1), 32'(16*N + 2));
    check_planes("hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
